// File: rtl/acq_record_buffer.sv
// Record-window capture buffer: stores a programmed number of I/Q pairs in block RAM and serves them back to the host.
// Latency: a sample is written on the edge it is valid; a read word appears one cycle after its rd_req is accepted.
// Backpressure: none toward the sample source (1 sample/clk max); the host paces readout with rd_req.
module acq_record_buffer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic [31:0]         rec_len,
    input  logic                in_val,
    input  logic [DATA_W-1:0]   in_i,
    input  logic [DATA_W-1:0]   in_q,
    input  logic                rd_req,
    output logic [2*DATA_W-1:0] rd_data,
    output logic                rd_valid,
    output logic                rd_last,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [ADDR_W:0]     count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] ONE = 1;

    typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, READY, READOUT} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W:0]     rd_ptr;
    logic [ADDR_W:0]     len_q;
    logic [2*DATA_W-1:0] mem [DEPTH];

    logic arm_ok;
    logic wr_en;
    logic rd_en;

    assign arm_ok = arm && (state == IDLE || state == READY || state == READOUT);
    assign wr_en  = !rst && in_val && (state == ARMED || state == CAPTURE);
    // arm takes priority over a same-cycle read request
    assign rd_en  = rd_req && !arm && (state == READY || state == READOUT) && (rd_ptr < count);

    assign busy = (state == ARMED) || (state == CAPTURE);
    assign done = (state == READY) || (state == READOUT);

    // RAM array has no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {in_i, in_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            len_q    <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_last  <= 1'b0;
            if (rd_en) begin
                rd_data <= mem[rd_ptr[ADDR_W-1:0]];
                rd_last <= (rd_ptr + ONE == count);
                rd_ptr  <= rd_ptr + ONE;
            end

            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count + ONE;
            end

            if (arm_ok) begin
                if (rec_len > 32'(DEPTH)) begin
                    len_q    <= ADDR_W'(0) + ONE * (ADDR_W+1)'(DEPTH);
                    overflow <= 1'b1;
                end else begin
                    len_q    <= rec_len[ADDR_W:0];
                    overflow <= 1'b0;
                end
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                state  <= (rec_len == 32'd0) ? READY : ARMED;
            end else begin
                case (state)
                    ARMED: begin
                        if (in_val) begin
                            state <= (count + ONE == len_q) ? READY : CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        if (in_val && (count + ONE == len_q)) begin
                            state <= READY;
                        end
                    end
                    READY: begin
                        if (rd_en) begin
                            state <= READOUT;
                        end
                    end
                    READOUT: begin
                        // the cycle that presents the final word is the last one in READOUT
                        if (rd_last) begin
                            state  <= IDLE;
                            rd_ptr <= '0;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acq_record_buffer.sv
// Bench for acq_record_buffer (ADDR_W=4): per-cycle vector table plus hand sequences for clamp, re-arm and reset.
// Inputs change 1 time unit after the rising edge; outputs are compared at the same point.
module tb_acq_record_buffer;

    localparam int AW = 4;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              arm;
    logic [31:0]       rec_len;
    logic              in_val;
    logic [DW-1:0]     in_i;
    logic [DW-1:0]     in_q;
    logic              rd_req;
    logic [2*DW-1:0]   rd_data;
    logic              rd_valid;
    logic              rd_last;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [AW:0]       count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    acq_record_buffer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .arm      (arm),
        .rec_len  (rec_len),
        .in_val   (in_val),
        .in_i     (in_i),
        .in_q     (in_q),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_last  (rd_last),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .count    (count)
    );

    typedef struct {
        logic        r;
        logic        a;
        logic [31:0] len;
        logic        v;
        logic [15:0] i;
        logic [15:0] q;
        logic        rq;
        logic        e_vld;
        logic        e_last;
        logic        e_busy;
        logic        e_done;
        logic        e_ovf;
        logic [4:0]  e_cnt;
        logic        e_chk;
        logic [31:0] e_dat;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic a, input logic [31:0] len,
                                input logic v, input int i, input int q, input logic rq,
                                input logic ev, input logic el, input logic eb, input logic ed,
                                input logic eo, input int ec, input logic echk, input logic [31:0] edat);
        vec_t t;
        t.r = r; t.a = a; t.len = len; t.v = v; t.i = 16'(i); t.q = 16'(q); t.rq = rq;
        t.e_vld = ev; t.e_last = el; t.e_busy = eb; t.e_done = ed; t.e_ovf = eo;
        t.e_cnt = 5'(ec); t.e_chk = echk; t.e_dat = edat;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic a, input logic [31:0] len, input logic v,
                         input int i, input int q, input logic rq);
        arm = a; rec_len = len; in_val = v; in_i = 16'(i); in_q = 16'(q); rd_req = rq;
        @(posedge clk);
        #1;
        arm = 1'b0; in_val = 1'b0; rd_req = 1'b0;
    endtask

    function automatic logic [31:0] word(input int i, input int q);
        return {16'(i), 16'(q)};
    endfunction

    initial begin
        rst = 1'b1; arm = 1'b0; rec_len = '0; in_val = 1'b0; in_i = '0; in_q = '0; rd_req = 1'b0;

        //                r  a  len v  i   q  rq   vld lst bsy dn ovf cnt chk data
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 0, 0, 1, 32'h0));
        // basic capture of 4 out of 6 samples
        tbl.push_back(mk(0, 1, 4, 0, 0,  0, 0,   0, 0, 1, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 1, -1, 0,   0, 0, 1, 0, 0, 1, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 2, -2, 0,   0, 0, 1, 0, 0, 2, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 3, -3, 0,   0, 0, 1, 0, 0, 3, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 4, -4, 0,   0, 0, 0, 1, 0, 4, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 5, -5, 0,   0, 0, 0, 1, 0, 4, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 6, -6, 0,   0, 0, 0, 1, 0, 4, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 1,   1, 0, 0, 1, 0, 4, 1, 32'h0001FFFF));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 1,   1, 0, 0, 1, 0, 4, 1, 32'h0002FFFE));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 1,   1, 0, 0, 1, 0, 4, 1, 32'h0003FFFD));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 1,   1, 1, 0, 1, 0, 4, 1, 32'h0004FFFC));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 1,   0, 0, 0, 0, 0, 4, 0, 32'h0));
        // gapped input, rec_len=3
        tbl.push_back(mk(0, 1, 3, 0, 0,  0, 0,   0, 0, 1, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 7, -7, 0,   0, 0, 1, 0, 0, 1, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0,   0, 0, 1, 0, 0, 1, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0,   0, 0, 1, 0, 0, 1, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 8, -8, 0,   0, 0, 1, 0, 0, 2, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0,   0, 0, 1, 0, 0, 2, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 9, -9, 0,   0, 0, 0, 1, 0, 3, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 10,-10,0,   0, 0, 0, 1, 0, 3, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 1,   1, 0, 0, 1, 0, 3, 1, 32'h0007FFF9));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 1,   1, 0, 0, 1, 0, 3, 1, 32'h0008FFF8));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 1,   1, 1, 0, 1, 0, 3, 1, 32'h0009FFF7));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 0, 3, 0, 32'h0));
        // zero length
        tbl.push_back(mk(0, 1, 0, 0, 0,  0, 0,   0, 0, 0, 1, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 1,   0, 0, 0, 1, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 1,   0, 0, 0, 1, 0, 0, 0, 32'h0));

        for (int n = 0; n < tbl.size(); n++) begin
            rst = tbl[n].r; arm = tbl[n].a; rec_len = tbl[n].len; in_val = tbl[n].v;
            in_i = tbl[n].i; in_q = tbl[n].q; rd_req = tbl[n].rq;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d rd_valid", n), 32'(rd_valid), 32'(tbl[n].e_vld));
            chk($sformatf("v%0d rd_last", n),  32'(rd_last),  32'(tbl[n].e_last));
            chk($sformatf("v%0d busy", n),     32'(busy),     32'(tbl[n].e_busy));
            chk($sformatf("v%0d done", n),     32'(done),     32'(tbl[n].e_done));
            chk($sformatf("v%0d overflow", n), 32'(overflow), 32'(tbl[n].e_ovf));
            chk($sformatf("v%0d count", n),    32'(count),    32'(tbl[n].e_cnt));
            if (tbl[n].e_chk) chk($sformatf("v%0d rd_data", n), rd_data, tbl[n].e_dat);
        end
        rst = 1'b0; arm = 1'b0; in_val = 1'b0; rd_req = 1'b0;

        // overflow / clamp: 20 requested, depth 16
        drive(1, 20, 0, 0, 0, 0);
        chk("ovf flag", 32'(overflow), 32'd1);
        chk("ovf busy", 32'(busy), 32'd1);
        for (int k = 0; k < 25; k++) drive(0, 0, 1, 100 + k, 200 + k, 0);
        chk("ovf count", 32'(count), 32'd16);
        chk("ovf done", 32'(done), 32'd1);
        for (int k = 0; k < 16; k++) begin
            drive(0, 0, 0, 0, 0, 1);
            chk($sformatf("ovf rd%0d valid", k), 32'(rd_valid), 32'd1);
            chk($sformatf("ovf rd%0d data", k), rd_data, word(100 + k, 200 + k));
            chk($sformatf("ovf rd%0d last", k), 32'(rd_last), 32'(k == 15));
        end
        drive(0, 0, 0, 0, 0, 1);
        chk("ovf end valid", 32'(rd_valid), 32'd0);
        chk("ovf end done", 32'(done), 32'd0);
        chk("ovf sticky", 32'(overflow), 32'd1);

        // re-arm colliding with a read after 2 of 5 words
        drive(1, 5, 0, 0, 0, 0);
        chk("rearm clears ovf", 32'(overflow), 32'd0);
        for (int k = 0; k < 5; k++) drive(0, 0, 1, 20 + k, 40 + k, 0);
        chk("col count", 32'(count), 32'd5);
        drive(0, 0, 0, 0, 0, 1);
        chk("col w0", rd_data, word(20, 40));
        drive(0, 0, 0, 0, 0, 1);
        chk("col w1 valid", 32'(rd_valid), 32'd1);
        chk("col w1 data", rd_data, word(21, 41));
        chk("col w1 last", 32'(rd_last), 32'd0);
        drive(1, 2, 0, 0, 0, 1);
        chk("col dropped rd", 32'(rd_valid), 32'd0);
        chk("col busy", 32'(busy), 32'd1);
        chk("col done", 32'(done), 32'd0);
        chk("col count0", 32'(count), 32'd0);
        drive(0, 0, 1, 50, 60, 0);
        drive(0, 0, 1, 51, 61, 0);
        chk("col recap done", 32'(done), 32'd1);
        drive(0, 0, 0, 0, 0, 1);
        chk("col new w0", rd_data, word(50, 60));
        chk("col new w0 last", 32'(rd_last), 32'd0);
        drive(0, 0, 0, 0, 0, 1);
        chk("col new w1", rd_data, word(51, 61));
        chk("col new w1 last", 32'(rd_last), 32'd1);

        // reset mid-capture
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 8, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 1, 0);
        drive(0, 0, 1, 2, 2, 0);
        chk("rst pre count", 32'(count), 32'd2);
        rst = 1'b1;
        drive(0, 0, 1, 3, 3, 0);
        rst = 1'b0;
        chk("rst count", 32'(count), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst ovf", 32'(overflow), 32'd0);
        chk("rst valid", 32'(rd_valid), 32'd0);
        chk("rst last", 32'(rd_last), 32'd0);
        chk("rst data", rd_data, 32'h0);
        for (int k = 0; k < 3; k++) drive(0, 0, 1, 9, 9, 0);
        chk("idle no write", 32'(count), 32'd0);
        chk("idle busy", 32'(busy), 32'd0);
        drive(0, 0, 0, 0, 0, 1);
        chk("idle rd ignored", 32'(rd_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acq_record_buffer.md
Name: acq_record_buffer

Overview:
Capture-side consumer of the demodulated I/Q stream that the `operations` block emits during the record window. It stores exactly the programmed number of valid I/Q pairs into on-chip block RAM, then lets the host/PCIe side read them back word-by-word with a request/valid handshake. It sits between `operations` (data_out_i/q, signal_val) and the host register/DMA interface.

Parameters:
ADDR_W, 10, buffer address width; depth = 2**ADDR_W samples
DATA_W, 16, width of each of I and Q

Ports:
clk  in  1  system clock, 200 MHz, same domain as `operations`
rst  in  1  synchronous, active-high reset
arm  in  1  single-cycle pulse; latch rec_len and begin waiting for data
rec_len  in  32  number of I/Q pairs to capture (same units as record len in time_len_data)
in_val  in  1  input sample valid (connect to signal_val)
in_i  in  DATA_W  signed I sample (data_out_i)
in_q  in  DATA_W  signed Q sample (data_out_q)
rd_req  in  1  host read request, one word per asserted cycle
rd_data  out  2*DATA_W  {I, Q} packed, I in MSBs
rd_valid  out  1  rd_data valid this cycle
rd_last  out  1  with rd_valid, marks final stored word
busy  out  1  high in ARMED or CAPTURE
done  out  1  high in READY or READOUT (data available)
overflow  out  1  sticky: rec_len exceeded depth at last arm
count  out  ADDR_W+1  number of pairs stored so far

Behaviour:
- Reset (sync, rst=1 at a clk edge): state=IDLE, wr_ptr=rd_ptr=0, count=0. rd_valid, rd_last, busy, done, and overflow are 0. rd_data is 0. RAM contents are not cleared.
- FSM states: IDLE, ARMED, CAPTURE, READY, READOUT.
- IDLE: on arm:
  - len_q = min(rec_len, 2**ADDR_W).
  - overflow = (rec_len > 2**ADDR_W).
  - wr_ptr=0, count=0.
  - If len_q==0, go to READY with done=1 and count=0; otherwise go to ARMED.
- ARMED: wait for in_val. The first in_val cycle writes into RAM and moves the FSM to CAPTURE; that sample is stored.
- Write rule (ARMED/CAPTURE): each cycle with in_val=1 writes {in_i,in_q} at wr_ptr, then wr_ptr+1 and count+1. in_val low stalls with no write; gaps are allowed.
- CAPTURE exits to READY on the same edge that writes sample number len_q. count==len_q from the next cycle; no further writes occur.
- arm in ARMED/CAPTURE is ignored.
- READY: rd_req accepted when rd_ptr<count, then go to READOUT. If count==0, rd_req is ignored.
- READOUT:
  - An accepted rd_req reads RAM[rd_ptr], and rd_ptr increments.
  - Read latency is exactly 1 cycle: rd_valid=1 with rd_data on the cycle after acceptance.
  - Back-to-back rd_req gives one word per cycle.
  - rd_last=1 with the word at address count-1.
  - The cycle after rd_last, state=IDLE, done=0, rd_ptr=0.
  - rd_req arriving while the last word is in flight is ignored.
- arm in READY/READOUT discards the buffer (rd_ptr=0, any in-flight read still completes its rd_valid) and re-arms exactly as from IDLE. Simultaneous arm and rd_req: arm wins, rd_req dropped.
- Data rate is 1 sample per clk max; no backpressure to `operations`.
- rst asserted mid-capture or mid-readout aborts immediately to IDLE with all flags cleared.

Test Plan:
- Basic capture: arm with rec_len=4, then in_val high for 6 cycles with I=1..6, Q=-1..-6. Required: count=4, done=1. Four rd_req cycles return {1,-1},{2,-2},{3,-3},{4,-4} at 1-cycle latency, with rd_last on the 4th word, then IDLE.
- Gapped input: rec_len=3 with in_val pattern 1,0,0,1,0,1. Required: stores exactly 3 samples; busy drops on the edge after the third valid.
- Overflow/clamp (ADDR_W=4): rec_len=20 with 25 valid samples. Required: overflow=1, count=16, readout yields 16 words with rd_last on the 16th.
- Zero length: rec_len=0. Required: immediately done=1, count=0; rd_req produces no rd_valid.
- Re-arm and collision: in READOUT after 2 of 5 words, assert arm and rd_req together. Required: the in-flight word is still delivered, rd_req is dropped, state=ARMED, done=0, and a new capture overwrites from address 0.
- Reset mid-capture: rst after 2 of 8 samples. Required: next cycle all outputs 0 and IDLE; in_val without arm writes nothing (count stays 0).
